// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture states, trigger modes, buffer depth.
// Used by the capture controller and the display stage; no logic, no latency, no flow control.
package la_pkg;

  localparam int SAMPLE_BUFF_SIZE = 160;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] TRIG_IMM  = 2'b00;
  localparam logic [1:0] TRIG_RISE = 2'b01;
  localparam logic [1:0] TRIG_FALL = 2'b10;
  localparam logic [1:0] TRIG_ANY  = 2'b11;

  // Edge modes need a previous sample from this capture before they can fire.
  function automatic logic trig_hit(input logic [1:0] mode, input logic prev_valid,
                                    input logic prev, input logic cur);
    case (mode)
      TRIG_IMM:  trig_hit = 1'b1;
      TRIG_RISE: trig_hit = prev_valid & ~prev & cur;
      TRIG_FALL: trig_hit = prev_valid & prev & ~cur;
      default:   trig_hit = prev_valid & (prev ^ cur);
    endcase
  endfunction

endpackage

// File: rtl/sample_prescaler.sv
// Sample-tick divider: tick when count == div, i.e. one tick every div+1 clocks; combinational tick.
// No backpressure; held at zero while disabled, restarted from zero by clear.
module sample_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = enable && !clear && (count == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count == div) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sample_capture_controller.sv
// Logic-analyzer front end: sync probes, divide to sample ticks, run pre/trigger/post capture into SIPO buffers.
// Probe-to-shift latency 3 clocks plus up to sample_div+1; no backpressure, buffers accept every shift strobe.
module sample_capture_controller #(
  parameter int CHANNEL_COUNT    = 10,
  parameter int SAMPLE_BUFF_SIZE = la_pkg::SAMPLE_BUFF_SIZE,
  parameter int DIV_WIDTH        = 16,
  localparam int TCW             = $clog2(CHANNEL_COUNT),
  localparam int PW              = $clog2(SAMPLE_BUFF_SIZE + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_COUNT-1:0] chan_in,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [DIV_WIDTH-1:0]     sample_div,
  input  logic [TCW-1:0]           trig_chan,
  input  logic [1:0]               trig_mode,
  input  logic [PW-1:0]            pre_trig,
  output logic                     shift,
  output logic [CHANNEL_COUNT-1:0] s_in,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               state
);

  import la_pkg::*;

  localparam logic [PW-1:0] PRE_MAX = PW'(SAMPLE_BUFF_SIZE - 1);
  localparam logic [PW-1:0] BUFF_P  = PW'(SAMPLE_BUFF_SIZE);

  state_t                 st;
  logic [CHANNEL_COUNT-1:0] sync1, sync2;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [TCW-1:0]         tc_q;
  logic [1:0]             mode_q;
  logic [PW-1:0]          pre_q, cnt;
  logic                   prev, prev_valid, fin;

  logic                   in_capture, start, tick, cur, hit;
  logic [PW-1:0]          pre_clamped, post_len;
  logic [TCW-1:0]         tc_clamped;

  assign in_capture  = (st == ST_PRE) || (st == ST_ARMED) || (st == ST_POST);
  assign start       = arm && !abort && ((st == ST_IDLE) || (st == ST_DONE));
  assign pre_clamped = (pre_trig > PRE_MAX) ? PRE_MAX : pre_trig;
  assign tc_clamped  = (32'(trig_chan) >= 32'(CHANNEL_COUNT)) ? '0 : trig_chan;
  assign post_len    = BUFF_P - pre_q;
  assign cur         = sync2[tc_q];
  assign hit         = trig_hit(mode_q, prev_valid, prev, cur);
  assign state       = st;

  // fin marks the cycle the final shift strobe is on the output; ticks are suppressed then.
  sample_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (in_capture && !fin),
    .clear  (start),
    .div    (div_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= chan_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= ST_IDLE;
      shift      <= 1'b0;
      s_in       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      prev       <= 1'b0;
      prev_valid <= 1'b0;
      fin        <= 1'b0;
      div_q      <= '0;
      tc_q       <= '0;
      mode_q     <= '0;
      pre_q      <= '0;
    end else begin
      shift <= 1'b0;
      if (abort) begin
        st   <= ST_IDLE;
        busy <= 1'b0;
        done <= 1'b0;
        fin  <= 1'b0;
      end else if (start) begin
        div_q      <= sample_div;
        tc_q       <= tc_clamped;
        mode_q     <= trig_mode;
        pre_q      <= pre_clamped;
        cnt        <= '0;
        prev_valid <= 1'b0;
        fin        <= 1'b0;
        busy       <= 1'b1;
        done       <= 1'b0;
        st         <= (pre_clamped != '0) ? ST_PRE : ST_ARMED;
      end else if (fin) begin
        st   <= ST_DONE;
        busy <= 1'b0;
        done <= 1'b1;
        fin  <= 1'b0;
      end else if (tick) begin
        shift      <= 1'b1;
        s_in       <= sync2;
        prev       <= cur;
        prev_valid <= 1'b1;
        case (st)
          ST_PRE: begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == pre_q) st <= ST_ARMED;
          end
          ST_ARMED: begin
            // The trigger sample is post sample 1.
            if (hit) begin
              cnt <= PW'(1);
              if (post_len == PW'(1)) fin <= 1'b1;
              else st <= ST_POST;
            end
          end
          ST_POST: begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == post_len) fin <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_capture_controller.sv
// Randomized bench for sample_capture_controller; a shift monitor feeds a capture-level reference model.
module tb_sample_capture_controller;
  import la_pkg::*;

  localparam int CH  = 10;
  localparam int BUF = 160;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          reset, arm, abort, shift, busy, done;
  logic [CH-1:0] chan_in, s_in;
  logic [DW-1:0] sample_div;
  logic [3:0]    trig_chan;
  logic [1:0]    trig_mode;
  logic [7:0]    pre_trig;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int arm_cyc = 0;
  int done_cyc = -1;
  bit done_seen = 0;
  logic done_q = 1'b0;
  bit force_en = 0;
  int force_ch = 0;
  logic force_val = 1'b0;

  logic [CH-1:0] drv [0:65535];
  logic [CH-1:0] samp[$];
  logic [CH-1:0] expd[$];
  int            shc[$];

  sample_capture_controller #(.CHANNEL_COUNT(CH), .SAMPLE_BUFF_SIZE(BUF), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .chan_in(chan_in), .arm(arm), .abort(abort),
    .sample_div(sample_div), .trig_chan(trig_chan), .trig_mode(trig_mode), .pre_trig(pre_trig),
    .shift(shift), .s_in(s_in), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Every shift strobe is one sample entering the buffers; the probe value it must carry
  // was driven three cycles earlier.
  always @(negedge clk) begin
    if (shift === 1'b1) begin
      samp.push_back(s_in);
      shc.push_back(cyc);
      expd.push_back(cyc >= 3 ? drv[cyc-3] : '0);
    end
    if (done === 1'b1 && done_q !== 1'b1 && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
    done_q = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chan_in = CH'($urandom);
    if (force_en) chan_in[force_ch] = force_val;
    drv[cyc] = chan_in;
  endtask

  task automatic arm_cap(input int div, input int pre, input int tc, input int md);
    sample_div = DW'(div);
    pre_trig   = 8'(pre);
    trig_chan  = 4'(tc);
    trig_mode  = 2'(md);
    samp.delete(); shc.delete(); expd.delete();
    done_seen = 0;
    arm = 1'b1;
    arm_cyc = cyc;
    step();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin step(); n++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b required 1 within %0d cycles", nm, done, budget);
    end
  endtask

  task automatic wait_samples(input int k, input int budget, input string nm);
    int n = 0;
    while (samp.size() < k && n < budget) begin step(); n++; end
    checks++;
    if (samp.size() < k) begin
      errors++;
      $display("FAIL %s_shift_timeout: got %0d shifts required %0d", nm, samp.size(), k);
    end
  endtask

  // Reference model: the first sample at or after the pre-trigger window that satisfies the
  // trigger rule is the trigger; the capture then holds BUF-pre samples from it onward.
  task automatic check_capture(input string nm, input int div, input int pre_eff,
                               input int tc_eff, input int md);
    int n, ti, bad_sp, bad_d, exp_total, first, last;
    logic c, p, h;
    step();
    n = samp.size();
    first = (n > 0) ? shc[0] : -1;
    last  = (n > 0) ? shc[n-1] : -2;
    checks++;
    if (first !== arm_cyc + div + 2) begin
      errors++;
      $display("FAIL %s_first_shift: cycle %0d required %0d", nm, first, arm_cyc + div + 2);
    end
    bad_sp = 0;
    for (int i = 1; i < n; i++) if (shc[i] - shc[i-1] != div + 1) bad_sp++;
    checks++;
    if (bad_sp !== 0) begin
      errors++;
      $display("FAIL %s_spacing: %0d gaps differ from required %0d clocks", nm, bad_sp, div + 1);
    end
    bad_d = 0;
    for (int i = 0; i < n; i++) if (samp[i] !== expd[i]) bad_d++;
    checks++;
    if (bad_d !== 0) begin
      errors++;
      $display("FAIL %s_sample_data: %0d samples wrong, required 0", nm, bad_d);
    end
    ti = -1;
    for (int i = pre_eff; i < n && ti < 0; i++) begin
      c = samp[i][tc_eff];
      h = 1'b0;
      if (md == 0) h = 1'b1;
      else if (i > 0) begin
        p = samp[i-1][tc_eff];
        if (md == 1) h = !p && c;
        else if (md == 2) h = p && !c;
        else h = (p != c);
      end
      if (h) ti = i;
    end
    exp_total = (ti < 0) ? -1 : ti + BUF - pre_eff;
    checks++;
    if (n !== exp_total) begin
      errors++;
      $display("FAIL %s_shift_count: %0d shifts required %0d (trigger index %0d)", nm, n, exp_total, ti);
    end
    checks++;
    if (!done_seen || done_cyc !== last + 1) begin
      errors++;
      $display("FAIL %s_done_timing: done rose at cycle %0d required %0d", nm, done_cyc, last + 1);
    end
    checks++;
    if (state !== 3'd4 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s_final: state=%0d busy=%b done=%b required 4/0/1", nm, state, busy, done);
    end
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({state, shift, busy, done} !== 6'b0 || s_in !== '0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d shift=%b busy=%b done=%b s_in=%h required all 0",
               state, shift, busy, done, s_in);
    end
    reset = 1'b0;
    step(); step();
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: state=%0d busy=%b required 0/0", state, busy);
    end
  endtask

  task automatic test_immediate();
    int k;
    force_en = 0;
    arm_cap(0, 0, 0, TRIG_IMM);
    wait_done(400, "imm");
    check_capture("imm", 0, 0, 0, TRIG_IMM);
    checks++;
    if (samp.size() !== BUF) begin
      errors++;
      $display("FAIL imm_total: %0d shifts required %0d", samp.size(), BUF);
    end
    k = samp.size();
    repeat (10) step();
    checks++;
    if (samp.size() !== k || done !== 1'b1) begin
      errors++;
      $display("FAIL imm_frozen: %0d shifts after done, done=%b required 0 shifts, done 1", samp.size() - k, done);
    end
  endtask

  task automatic test_rising();
    force_en = 1; force_ch = 2; force_val = 1'b0;
    repeat (3) step();
    arm_cap(3, 40, 2, TRIG_RISE);
    wait_samples(10, 200, "rise_pre");
    checks++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rise_in_pre: state=%0d busy=%b required 1/1", state, busy);
    end
    // Mid-capture input changes must not affect the latched settings.
    sample_div = 16'd0; pre_trig = 8'd0;
    wait_samples(100, 1000, "rise_armed");
    checks++;
    if (state !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rise_armed: state=%0d busy=%b required 2/1", state, busy);
    end
    force_val = 1'b1;
    wait_done(2000, "rise");
    check_capture("rise", 3, 40, 2, TRIG_RISE);
  endtask

  task automatic test_falling();
    force_en = 1; force_ch = 5; force_val = 1'b1;
    repeat (3) step();
    arm_cap(1, 30, 5, TRIG_FALL);
    wait_samples(400, 2000, "fall_hold");
    checks++;
    if (done !== 1'b0 || state !== 3'd2) begin
      errors++;
      $display("FAIL fall_no_edge: done=%b state=%0d required 0/2", done, state);
    end
    force_val = 1'b0;
    wait_done(1000, "fall");
    check_capture("fall", 1, 30, 5, TRIG_FALL);
  endtask

  task automatic test_clamp();
    int n;
    force_en = 1; force_ch = 0; force_val = 1'b0;
    repeat (3) step();
    arm_cap(0, 200, 12, TRIG_RISE);
    wait_samples(170, 400, "clamp_hold");
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL clamp_armed: state=%0d required 2", state);
    end
    force_val = 1'b1;
    wait_done(100, "clamp");
    check_capture("clamp", 0, 159, 0, TRIG_RISE);
    n = samp.size();
    checks++;
    if (n < 2 || samp[n-1][0] !== 1'b1 || samp[n-2][0] !== 1'b0) begin
      errors++;
      $display("FAIL clamp_newest_is_trigger: last ch0 samples not 0 then 1 (count %0d)", n);
    end
  endtask

  task automatic test_abort();
    int k;
    force_en = 0;
    arm_cap(2, 0, 0, TRIG_IMM);
    wait_samples(20, 200, "abort_post");
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL abort_in_post: state=%0d required 3", state);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || shift !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: state=%0d busy=%b shift=%b required 0/0/0", state, busy, shift);
    end
    k = samp.size();
    repeat (20) step();
    checks++;
    if (samp.size() !== k || state !== 3'd0) begin
      errors++;
      $display("FAIL abort_no_shift: %0d extra shifts state=%0d required 0 and 0", samp.size() - k, state);
    end
    samp.delete();
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arm_abort_collision: state=%0d busy=%b required 0/0", state, busy);
    end
    repeat (10) step();
    checks++;
    if (samp.size() !== 0) begin
      errors++;
      $display("FAIL arm_abort_no_shift: %0d shifts required 0", samp.size());
    end
  endtask

  task automatic test_arm_busy();
    force_en = 0;
    arm_cap(1, 50, 0, TRIG_IMM);
    wait_samples(10, 100, "armbusy_pre");
    sample_div = 16'd0; pre_trig = 8'd0; trig_mode = TRIG_RISE;
    arm = 1'b1;
    step();
    arm = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL arm_while_busy: state=%0d required 1", state);
    end
    wait_done(1000, "armbusy");
    check_capture("armbusy", 1, 50, 0, TRIG_IMM);
  endtask

  task automatic test_reset_mid();
    force_en = 0;
    arm_cap(2, 60, 0, TRIG_IMM);
    wait_samples(10, 200, "rstmid_pre");
    step();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({state, shift, busy, done} !== 6'b0 || s_in !== '0) begin
      errors++;
      $display("FAIL reset_mid_pre: state=%0d shift=%b busy=%b done=%b s_in=%h required all 0",
               state, shift, busy, done, s_in);
    end
    step(); step();
    reset = 1'b0;
    step();
    arm_cap(0, 20, 3, TRIG_ANY);
    wait_done(1000, "rstmid");
    check_capture("rstmid", 0, 20, 3, TRIG_ANY);
  endtask

  task automatic test_random();
    int div, pre, tc, md;
    force_en = 0;
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(0, 3);
      pre = $urandom_range(0, 200);
      tc  = $urandom_range(0, 15);
      md  = $urandom_range(0, 3);
      arm_cap(div, pre, tc, md);
      wait_done(5000, "rand");
      check_capture("rand", div, (pre > BUF - 1) ? BUF - 1 : pre, (tc >= CH) ? 0 : tc, md);
    end
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; chan_in = '0;
    sample_div = '0; trig_chan = '0; trig_mode = '0; pre_trig = '0;
    drv[0] = '0;
    test_reset();
    test_immediate();
    test_rising();
    test_falling();
    test_clamp();
    test_abort();
    test_arm_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
